// File: rtl/clk_ratio_meter_pkg.sv
// Shared definitions for the divided-clock ratio meter: FSM encoding and
// the width of the consecutive-match counter used for lock detection.
package clk_ratio_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } meter_state_t;

  // Consecutive equal-period counter width (LOCK_CNT may be up to 15)
  localparam int MATCH_W = 4;

endpackage

// File: rtl/clk_ratio_meter_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, plus a third flop that
// turns the synchronized level into a single-cycle rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Resample the asynchronous input and keep one extra stage for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a divided clock in clk_in cycles, flags
// near-50% duty, tracks lock on repeated equal periods and missing edges.
module clk_ratio_meter
  import clk_ratio_meter_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 255,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             div_clk_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             duty_ok,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [MATCH_W-1:0] MATCH_MAX = '1;
  localparam logic [MATCH_W-1:0] LOCK_TH   = MATCH_W'(LOCK_CNT - 1);

  logic               level;
  logic               rise;
  meter_state_t       state;
  logic [CNT_W-1:0]   per_cnt;
  logic [CNT_W-1:0]   hi_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic               have_ref;

  logic [CNT_W-1:0]   per_inc;
  logic [CNT_W-1:0]   hi_inc;
  logic [MATCH_W-1:0] match_inc;
  logic [CNT_W:0]     duty_diff;
  logic               duty_pass;
  logic               same_period;

  sync_edge_det u_sync (
    .clk   (clk_in),
    .rst_n (rst_n),
    .din   (div_clk_in),
    .level (level),
    .rise  (rise)
  );

  // Saturating increments: counters stick at all-ones instead of wrapping
  assign per_inc   = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_W'(1);
  assign hi_inc    = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + CNT_W'(1);
  assign match_inc = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + MATCH_W'(1);

  // 2*high - period at CNT_W+1 bits; high <= period keeps it in signed range
  assign duty_diff = {hi_cnt, 1'b0} - {1'b0, per_cnt};
  assign duty_pass = (duty_diff == '0) || (duty_diff == (CNT_W+1)'(1)) || (duty_diff == '1);

  // The first period after arming is only a reference and can never match
  assign same_period = have_ref && (per_cnt == period_out);

  // Measurement FSM with all status outputs registered
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      match_cnt  <= '0;
      have_ref   <= 1'b0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      duty_ok    <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        // Reported values and duty_ok hold; status and counters clear
        state     <= ST_IDLE;
        per_cnt   <= '0;
        hi_cnt    <= '0;
        match_cnt <= '0;
        have_ref  <= 1'b0;
        locked    <= 1'b0;
        timeout   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            per_cnt   <= '0;
            hi_cnt    <= '0;
            match_cnt <= '0;
            have_ref  <= 1'b0;
            locked    <= 1'b0;
            state     <= ST_ARM;
          end
          ST_ARM: begin
            if (rise) begin
              state   <= ST_MEASURE;
              per_cnt <= CNT_W'(1);
              hi_cnt  <= CNT_W'(level);
              timeout <= 1'b0;
            end else begin
              per_cnt <= per_inc;
              if (per_cnt >= TIMEOUT_V) begin
                timeout <= 1'b1;
              end
            end
          end
          ST_MEASURE: begin
            if (rise) begin
              // A rise always wins over a coincident timeout
              period_out <= per_cnt;
              high_out   <= hi_cnt;
              duty_ok    <= duty_pass;
              meas_valid <= 1'b1;
              per_cnt    <= CNT_W'(1);
              hi_cnt     <= CNT_W'(level);
              timeout    <= 1'b0;
              have_ref   <= 1'b1;
              if (same_period) begin
                match_cnt <= match_inc;
                locked    <= (match_inc >= LOCK_TH);
              end else begin
                match_cnt <= '0;
                locked    <= 1'b0;
              end
            end else if (per_cnt >= TIMEOUT_V) begin
              timeout   <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
              have_ref  <= 1'b0;
              per_cnt   <= '0;
              hi_cnt    <= '0;
              state     <= ST_ARM;
            end else begin
              per_cnt <= per_inc;
              if (level) begin
                hi_cnt <= hi_inc;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed-plus-random bench for clk_ratio_meter. A waveform generator plays
// a list of (period, high half-cycles) records; the checker predicts each
// report from that list: period, sampled high time, duty and lock run length.
`timescale 1ns/1ps
module tb_clk_ratio_meter;

  localparam int CNT_W    = 8;
  localparam int TIMEOUT  = 255;
  localparam int LOCK_CNT = 3;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic             div_clk_in;
  logic             enable;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             meas_valid;
  logic             duty_ok;
  logic             locked;
  logic             timeout;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Generator work list and the checker's copy of the same records
  int plan_n[$];
  int plan_l[$];
  int exp_n[$];
  int exp_l[$];
  bit gen_busy      = 1'b0;
  int last_rise_cyc = 0;

  clk_ratio_meter #(
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT),
    .LOCK_CNT (LOCK_CNT)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .div_clk_in (div_clk_in),
    .enable     (enable),
    .period_out (period_out),
    .high_out   (high_out),
    .meas_valid (meas_valid),
    .duty_ok    (duty_ok),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Each period rises 2ns after a clk_in posedge and stays high for l
  // half-cycles, so exactly floor(l/2) posedges sample it high.
  initial begin
    int n;
    int l;
    div_clk_in = 1'b0;
    forever begin
      @(posedge clk_in);
      #2;
      if (plan_n.size() > 0) begin
        gen_busy = 1'b1;
        n = plan_n.pop_front();
        l = plan_l.pop_front();
        div_clk_in = 1'b1;
        last_rise_cyc = cyc;
        #(5 * l);
        div_clk_in = 1'b0;
        #(10 * n - 3 - 5 * l);
      end else begin
        gen_busy = 1'b0;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk_in);
  endtask

  task automatic add_periods(input int n, input int l, input int reps);
    for (int r = 0; r < reps; r++) begin
      plan_n.push_back(n);
      plan_l.push_back(l);
      exp_n.push_back(n);
      exp_l.push_back(l);
    end
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk_in);
      if (meas_valid === 1'b1) seen = 1'b1;
    end
  endtask

  // Check the first cnt reports against the queued period records
  task automatic run_checks(input int cnt);
    int prev;
    int run;
    int h;
    int d;
    bit seen;
    prev = -1;
    run  = 0;
    for (int i = 0; i < cnt; i++) begin
      wait_valid(seen);
      check($sformatf("meas_seen[%0d]", i), 32'(seen), 1);
      if (exp_n[i] == prev) run++;
      else run = 1;
      prev = exp_n[i];
      h = exp_l[i] / 2;
      d = 2 * h - exp_n[i];
      check($sformatf("period[%0d]", i), 32'(period_out), exp_n[i]);
      check($sformatf("high[%0d]", i), 32'(high_out), h);
      check($sformatf("duty[%0d]", i), 32'(duty_ok), (d >= -1 && d <= 1) ? 1 : 0);
      check($sformatf("locked[%0d]", i), 32'(locked), (run >= LOCK_CNT) ? 1 : 0);
      check($sformatf("timeout_clr[%0d]", i), 32'(timeout), 0);
      @(negedge clk_in);
      check($sformatf("pulse_width[%0d]", i), 32'(meas_valid), 0);
    end
  endtask

  task automatic wait_gen_done();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk_in);
      if (plan_n.size() == 0 && !gen_busy) done = 1'b1;
    end
    check("gen_done", 32'(done), 1);
    exp_n.delete();
    exp_l.delete();
  endtask

  // After the source stops: timeout must appear about TIMEOUT+3 cycles
  // after the last rise, drop lock, and produce no report.
  task automatic expect_timeout();
    bit seen;
    int spurious;
    int lat;
    seen = 1'b0;
    spurious = 0;
    lat = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk_in);
      if (meas_valid !== 1'b0) spurious++;
      if (timeout === 1'b1) begin
        seen = 1'b1;
        lat = cyc - last_rise_cyc;
      end
    end
    check("timeout_seen", 32'(seen), 1);
    check("timeout_latency", 32'((lat >= TIMEOUT + 2 && lat <= TIMEOUT + 4) ? 1 : 0), 1);
    check("timeout_unlock", 32'(locked), 0);
    check("timeout_no_valid", 32'(spurious), 0);
    tick(5);
    check("timeout_sticky", 32'(timeout), 1);
  endtask

  task automatic run_phase();
    run_checks(exp_n.size() - 1);
    wait_gen_done();
    expect_timeout();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, 32'(period_out), 0);
    check({tag, "_high"}, 32'(high_out), 0);
    check({tag, "_valid"}, 32'(meas_valid), 0);
    check({tag, "_duty"}, 32'(duty_ok), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  initial begin
    int n;
    int l;
    int bad;
    rst_n  = 1'b0;
    enable = 1'b0;
    tick(3);
    check_zero("reset");
    rst_n = 1'b1;
    tick(2);
    check_zero("idle");
    enable = 1'b1;
    tick(2);

    // Divide-by-5, 50% duty with half-cycle edge
    add_periods(5, 5, 6);
    run_phase();
    // Divide-by-4 after timeout: first rise clears timeout
    add_periods(4, 4, 5);
    run_phase();
    // Divide-by-7 with one-cycle high pulse
    add_periods(7, 2, 5);
    run_phase();
    // Period switch 5 -> 7 while locked
    add_periods(5, 5, 5);
    add_periods(7, 7, 5);
    run_phase();

    // Random groups of repeated periods
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 4; k++) begin
        n = $urandom_range(2, 30);
        l = $urandom_range(2, 2 * n - 2);
        add_periods(n, l, $urandom_range(1, 4));
      end
      add_periods(3, 3, 1);
      run_phase();
    end

    // enable dropped while locked: status clears, reported values hold
    add_periods(5, 5, 10);
    run_checks(4);
    enable = 1'b0;
    tick(1);
    check("en_low_locked", 32'(locked), 0);
    check("en_low_timeout", 32'(timeout), 0);
    check("en_low_period", 32'(period_out), 5);
    check("en_low_high", 32'(high_out), 2);
    check("en_low_duty", 32'(duty_ok), 1);
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk_in);
      if (meas_valid !== 1'b0 || locked !== 1'b0) bad++;
    end
    check("en_low_quiet", 32'(bad), 0);
    wait_gen_done();
    enable = 1'b1;
    tick(2);

    // Reset asserted mid-period with the source still running
    add_periods(5, 5, 10);
    run_checks(3);
    tick(2);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    bad = 0;
    for (int k = 0; k < 3000 && (plan_n.size() > 0 || gen_busy); k++) begin
      @(negedge clk_in);
      if (meas_valid !== 1'b0 || locked !== 1'b0 || period_out !== '0) bad++;
    end
    check("reset_hold_quiet", 32'(bad), 0);
    exp_n.delete();
    exp_l.delete();
    @(negedge clk_in);
    rst_n = 1'b1;
    tick(5);
    check_zero("post_reset");
    // Clean re-arm after reset
    add_periods(5, 5, 5);
    run_phase();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
